stream_demux: RTL and testbench
===============================

# stream_demux

Parametrised 1-to-N valid/ready stream demultiplexer, successor to the team's combinational 1-to-2 demux. It routes each accepted input beat to exactly one of N_OUT registered output channels. The channel is chosen either by an explicit select field or by an internal round-robin pointer. Each output has a one-entry holding register, so a stalled consumer blocks only beats aimed at its own channel. It sits between a single producer and N independent consumers in the datapath.

## Interface
- N_OUT, 4: number of output channels, 2..16.
- DATA_W, 8: payload width, ≥1.
- SEL_W, derived as max(1, clog2(N_OUT)): select width; not user-overridden.
- clk  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- mode  in  1  0 = addressed (use in_sel), 1 = round-robin (use internal pointer).
- in_valid  in  1  producer has a beat.
- in_ready  out  1  block accepts the beat this cycle.
- in_data  in  DATA_W  payload.
- in_sel  in  SEL_W  target channel in addressed mode; ignored in round-robin mode.
- out_valid  out  N_OUT  per-channel beat present.
- out_ready  in  N_OUT  per-channel consumer accept.
- out_data  out  N_OUT*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W].
- sel_err  out  1  one-cycle pulse when a beat was dropped for an out-of-range in_sel.
- drop_cnt  out  8  saturating count of dropped beats.

## Operation
- Target t: in_sel when mode=0, rr_ptr when mode=1. mode is sampled per beat and may change on any cycle.
- Slot k is "free" when it is empty, or when it is full and out_valid[k] & out_ready[k] holds this cycle (drain and refill in the same cycle).
- Valid target (t < N_OUT):
  - in_ready = free(t).
  - Accept when in_valid & in_ready.
  - On accept, slot t loads in_data and out_valid[t] goes to 1 on the next edge.
- Invalid target (mode=0 and in_sel ≥ N_OUT, possible only when N_OUT is not a power of two):
  - in_ready = 1 and the beat is consumed without being delivered.
  - Next cycle: sel_err = 1 for one cycle.
  - drop_cnt increments and saturates at 255.
- Slot k clears when out_valid[k] & out_ready[k] and there is no simultaneous reload.
- out_data[k] holds its value while out_valid[k] = 1. It is don't-care when out_valid[k] = 0.
- rr_ptr advances only on an accepted beat in mode=1, wrapping from N_OUT-1 to 0. It holds in mode=0 and when stalled. It does not reset on a mode change.
- Round-robin never skips a full slot: the producer waits on rr_ptr's slot (strict order).
- Per-slot states: EMPTY → FULL on load; FULL → EMPTY on drain without reload; FULL → FULL on drain with reload.

## Timing
- Reset (rst_n = 0 at an edge):
  - All slots go EMPTY: out_valid = 0, out_data = 0.
  - rr_ptr = 0, sel_err = 0, drop_cnt = 0.
  - in_ready = 0 while rst_n = 0.
- Reset mid-transfer discards all held beats; no beat completes on the reset edge.
- Latency is 1 cycle from accept to out_valid[t].
- Throughput is 1 beat/cycle while consumers drain every cycle.
- in_ready is combinational from mode, in_sel, rr_ptr, slot state and out_ready[t]. There is no combinational path from in_valid to in_ready.
- out_valid and out_data come straight from registers, with no combinational path from inputs.
- Once out_valid[k] is asserted it stays asserted until that channel's handshake.

## Structure
- Package demux_pkg holds:
  - the mode constants MODE_ADDR = 0 and MODE_RR = 1;
  - the SEL_W calculation function;
  - the DROP_W = 8 constant.
- Sub-module demux_slot: a one-entry register with load, drain, valid, data and a free output, instantiated N_OUT times via generate.
- The top level holds target selection, rr_ptr, the in_ready mux, error detection and drop_cnt.

## Test plan
- Addressed routing, N_OUT=4, all out_ready=1: send 0xA0..0xA3 with in_sel = 0..3. Each out_valid[k] pulses 1 cycle after its accept with data 0xA0+k. in_ready stays 1 throughout.
- Round-robin wrap, mode=1: send 6 beats 0x10..0x15. Channels receive them in order 0,1,2,3,0,1, and rr_ptr ends at 2.
- Backpressure isolation, mode=0:
  - Hold out_ready[1]=0, fill slot 1 with 0x55, then present a beat for channel 1 → in_ready = 0.
  - A beat for channel 2 is accepted immediately.
  - Raise out_ready[1] → 0x55 drains, and the pending beat loads the same cycle; out_valid[1] stays 1.
- Invalid select, N_OUT=3, mode=0: send in_sel=3 with 0xEE → in_ready = 1. Next cycle sel_err = 1 for exactly one cycle, drop_cnt = 1, and no out_valid rises. Send 300 bad beats → drop_cnt saturates at 255.
- Reset mid-operation: with slots 0 and 2 full and rr_ptr = 3, drive rst_n = 0 for one edge. Afterwards all out_valid = 0, rr_ptr = 0, drop_cnt = 0, and the next mode=1 beat lands on channel 0.
- Mode switch: in mode=1, send 2 beats (rr_ptr = 2). Switch to mode=0 and send in_sel=0; rr_ptr stays 2. Switch back to mode=1; the next beat goes to channel 2.

Source files
------------

// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared constants, slot state type and select-width helper for stream_demux
package demux_pkg;

  localparam logic MODE_ADDR = 1'b0;
  localparam logic MODE_RR   = 1'b1;
  localparam int   DROP_W    = 8;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  // Select width never drops below one bit, even for two channels.
  function automatic int calc_sel_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/demux_slot.sv
// rtl/demux_slot.sv - one-entry output holding register with drain-and-refill
module demux_slot
  import demux_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic              free_o
);

  slot_state_e       state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;

  // Next state: a full slot can be refilled in the same cycle it drains.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    free_o  = 1'b0;
    case (state_q)
      SLOT_EMPTY: begin
        free_o = 1'b1;
        if (load_i) begin
          state_d = SLOT_FULL;
          data_d  = data_i;
        end
      end
      SLOT_FULL: begin
        free_o = ready_i;
        if (ready_i) begin
          if (load_i) begin
            data_d = data_i;
          end else begin
            state_d = SLOT_EMPTY;
          end
        end
      end
      default: begin
        state_d = SLOT_EMPTY;
      end
    endcase
  end

  // Slot state and payload registers; reset discards any held beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= SLOT_EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = (state_q == SLOT_FULL);
  assign data_o  = data_q;

endmodule

// File: rtl/stream_demux.sv
// rtl/stream_demux.sv - 1-to-N valid/ready demultiplexer with addressed and round-robin routing
module stream_demux
  import demux_pkg::*;
#(
  parameter  int N_OUT  = 4,
  parameter  int DATA_W = 8,
  localparam int SEL_W  = calc_sel_w(N_OUT)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mode,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  input  logic [SEL_W-1:0]        in_sel,
  output logic [N_OUT-1:0]        out_valid,
  input  logic [N_OUT-1:0]        out_ready,
  output logic [N_OUT*DATA_W-1:0] out_data,
  output logic                    sel_err,
  output logic [DROP_W-1:0]       drop_cnt
);

  logic [SEL_W-1:0]  rr_q, rr_d;
  logic              sel_err_q, sel_err_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic [SEL_W-1:0]  tgt;
  logic              tgt_ok;
  logic              accept;
  logic              drop;
  logic [N_OUT-1:0]  slot_free;
  logic [N_OUT-1:0]  slot_load;

  // Target selection and the in_ready mux; in_valid only qualifies accept.
  always_comb begin
    tgt      = (mode == MODE_RR) ? rr_q : in_sel;
    tgt_ok   = (32'(tgt) < N_OUT);
    in_ready = 1'b0;
    if (rst_n) begin
      in_ready = tgt_ok ? slot_free[tgt] : 1'b1;
    end
    accept = in_valid & in_ready;
    drop   = accept & ~tgt_ok;
  end

  // Round-robin pointer, error pulse and saturating drop counter updates.
  always_comb begin
    rr_d      = rr_q;
    sel_err_d = drop;
    drop_d    = drop_q;
    if (accept && (mode == MODE_RR)) begin
      rr_d = (32'(rr_q) == N_OUT - 1) ? '0 : rr_q + SEL_W'(1);
    end
    if (drop && (drop_q != {DROP_W{1'b1}})) begin
      drop_d = drop_q + DROP_W'(1);
    end
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_q      <= '0;
      sel_err_q <= 1'b0;
      drop_q    <= '0;
    end else begin
      rr_q      <= rr_d;
      sel_err_q <= sel_err_d;
      drop_q    <= drop_d;
    end
  end

  assign sel_err  = sel_err_q;
  assign drop_cnt = drop_q;

  for (genvar k = 0; k < N_OUT; k++) begin : g_slot
    assign slot_load[k] = accept & tgt_ok & (32'(tgt) == k);

    demux_slot #(
      .DATA_W(DATA_W)
    ) u_slot (
      .clk    (clk),
      .rst_n  (rst_n),
      .load_i (slot_load[k]),
      .data_i (in_data),
      .ready_i(out_ready[k]),
      .valid_o(out_valid[k]),
      .data_o (out_data[k*DATA_W +: DATA_W]),
      .free_o (slot_free[k])
    );
  end

endmodule

// File: tb/tb_stream_demux.sv
// tb/tb_stream_demux.sv - scoreboard bench driving a 4-channel and a 3-channel stream_demux
module tb_stream_demux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mode;
  logic        in_valid;
  logic [7:0]  in_data;
  logic [1:0]  in_sel;
  logic [3:0]  out_ready;

  logic        in_ready4, in_ready3;
  logic [3:0]  out_valid4;
  logic [2:0]  out_valid3;
  logic [31:0] out_data4;
  logic [23:0] out_data3;
  logic        sel_err4, sel_err3;
  logic [7:0]  drop_cnt4, drop_cnt3;

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;

  logic [7:0] sbq [2][4][$];
  bit         full_m [2][4];
  int         rr_m   [2];
  int         drop_m [2];
  bit         err_m  [2];

  always #5 clk = ~clk;

  stream_demux #(.N_OUT(4), .DATA_W(8)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid), .in_ready(in_ready4),
    .in_data(in_data), .in_sel(in_sel), .out_valid(out_valid4), .out_ready(out_ready),
    .out_data(out_data4), .sel_err(sel_err4), .drop_cnt(drop_cnt4)
  );

  stream_demux #(.N_OUT(3), .DATA_W(8)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid), .in_ready(in_ready3),
    .in_data(in_data), .in_sel(in_sel), .out_valid(out_valid3), .out_ready(out_ready[2:0]),
    .out_data(out_data3), .sel_err(sel_err3), .drop_cnt(drop_cnt3)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 4; k++) begin
        full_m[d][k] = 1'b0;
        sbq[d][k].delete();
      end
      rr_m[d]   = 0;
      drop_m[d] = 0;
      err_m[d]  = 1'b0;
    end
  endtask

  // One cycle: drive at posedge+1, predict and check at negedge+1, update the model.
  task automatic step(input bit m, input bit v, input int s, input logic [7:0] dt,
                      input logic [3:0] rdy, input bit rst);
    logic [3:0] r;
    r         = rst ? 4'h0 : rdy;
    mode      = m;
    in_valid  = v;
    in_sel    = 2'(s);
    in_data   = dt;
    out_ready = r;
    rst_n     = ~rst;
    @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      int n, t;
      bit exp_rdy, acc, err_next;
      n = (d == 0) ? 4 : 3;
      chk(d == 0 ? "sel_err4" : "sel_err3", d == 0 ? sel_err4 : sel_err3, err_m[d]);
      chk(d == 0 ? "drop_cnt4" : "drop_cnt3", d == 0 ? drop_cnt4 : drop_cnt3, drop_m[d]);
      t = m ? rr_m[d] : s;
      if (rst)         exp_rdy = 1'b0;
      else if (t >= n) exp_rdy = 1'b1;
      else             exp_rdy = !full_m[d][t] || r[t];
      chk(d == 0 ? "in_ready4" : "in_ready3", d == 0 ? in_ready4 : in_ready3, exp_rdy);
      if (rst) begin
        for (int k = 0; k < 4; k++) begin
          full_m[d][k] = 1'b0;
          sbq[d][k].delete();
        end
        rr_m[d]   = 0;
        drop_m[d] = 0;
        err_m[d]  = 1'b0;
      end else begin
        acc      = v && exp_rdy;
        err_next = acc && (t >= n);
        for (int k = 0; k < n; k++)
          if (full_m[d][k] && r[k]) full_m[d][k] = 1'b0;
        if (acc && t < n) begin
          full_m[d][t] = 1'b1;
          sbq[d][t].push_back(dt);
        end
        if (err_next && drop_m[d] < 255) drop_m[d]++;
        if (acc && m) rr_m[d] = (rr_m[d] + 1) % n;
        err_m[d] = err_next;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: every presented beat must match the oldest expected beat for its channel.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        for (int d = 0; d < 2; d++) begin
          int n;
          n = (d == 0) ? 4 : 3;
          for (int k = 0; k < n; k++) begin
            logic       vld;
            logic [7:0] dat;
            vld = (d == 0) ? out_valid4[k] : out_valid3[k];
            dat = (d == 0) ? out_data4[k*8 +: 8] : out_data3[k*8 +: 8];
            chk($sformatf("out_valid d%0d ch%0d", d, k), vld, sbq[d][k].size() != 0);
            if (vld === 1'b1 && sbq[d][k].size() != 0) begin
              chk($sformatf("out_data d%0d ch%0d", d, k), dat, sbq[d][k][0]);
              if (out_ready[k] === 1'b1) void'(sbq[d][k].pop_front());
            end
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; mode = 1'b0; in_valid = 1'b0; in_data = '0; in_sel = '0; out_ready = '0;
    repeat (2) @(posedge clk);
    #1;
    model_clear();
    chk("reset out_valid4", out_valid4, 0);
    chk("reset out_valid3", out_valid3, 0);
    chk("reset out_data4", out_data4, 0);
    chk("reset sel_err4", sel_err4, 0);
    chk("reset drop_cnt3", drop_cnt3, 0);
    chk("reset in_ready4", in_ready4, 0);
    mon_en = 1'b1;

    // Addressed routing, all consumers ready.
    for (int i = 0; i < 4; i++) step(0, 1, i, 8'hA0 + 8'(i), 4'hF, 0);
    step(0, 0, 0, 8'h00, 4'hF, 0);

    // Round-robin wrap.
    for (int i = 0; i < 6; i++) step(1, 1, 0, 8'h10 + 8'(i), 4'hF, 0);
    step(0, 0, 0, 8'h00, 4'hF, 0);

    // Backpressure isolation on channel 1.
    step(0, 1, 1, 8'h55, 4'b1101, 0);
    step(0, 1, 1, 8'h66, 4'b1101, 0);
    chk("bp blocked in_ready", in_ready4, 0);
    step(0, 1, 2, 8'h77, 4'b1101, 0);
    step(0, 1, 1, 8'h66, 4'hF, 0);
    chk("bp refill keeps valid", out_valid4[1], 1);
    step(0, 0, 0, 8'h00, 4'hF, 0);

    // Invalid select on the 3-channel instance, then saturation.
    step(0, 1, 3, 8'hEE, 4'hF, 0);
    chk("bad sel pulse", sel_err3, 1);
    chk("bad sel no valid", out_valid3, 0);
    step(0, 0, 0, 8'h00, 4'hF, 0);
    chk("bad sel pulse ends", sel_err3, 0);
    for (int i = 0; i < 300; i++) step(0, 1, 3, 8'(i), 4'hF, 0);
    step(0, 0, 0, 8'h00, 4'hF, 0);
    chk("drop_cnt saturates", drop_cnt3, 255);

    // Reset with held beats and a non-zero round-robin pointer.
    while (rr_m[0] != 3) step(1, 1, 0, 8'h20, 4'hF, 0);
    step(0, 1, 0, 8'h30, 4'h0, 0);
    step(0, 1, 2, 8'h32, 4'h0, 0);
    step(0, 0, 0, 8'h00, 4'h0, 1);
    chk("post-reset out_valid4", out_valid4, 0);
    chk("post-reset drop_cnt3", drop_cnt3, 0);
    step(1, 1, 0, 8'h40, 4'h0, 0);
    chk("post-reset rr lands ch0", out_valid4, 4'b0001);
    step(0, 0, 0, 8'h00, 4'hF, 0);

    // Mode switch keeps the round-robin pointer.
    step(1, 1, 0, 8'h50, 4'hF, 0);
    step(0, 1, 0, 8'h51, 4'hF, 0);
    step(1, 1, 0, 8'h52, 4'hF, 0);
    chk("mode switch lands ch2", out_valid4, 4'b0100);
    step(0, 0, 0, 8'h00, 4'hF, 0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 1), $urandom_range(0, 3) != 0, $urandom_range(0, 3),
           8'($urandom), 4'($urandom_range(0, 15)), $urandom_range(0, 99) == 0);

    repeat (3) step(0, 0, 0, 8'h00, 4'hF, 0);
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < 4; k++)
        chk($sformatf("drained d%0d ch%0d", d, k), sbq[d][k].size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
